// File: rtl/sprite_line_buffer_pkg.sv
// Shared constants for the sprite line buffer: sprite geometry, screen size,
// orientation codes and sprite IDs as stored in the sprite ROM.
package sprite_line_buffer_pkg;

    localparam int SPRITE_SIZE = 8;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;

    localparam logic [1:0] ORIENT_UP    = 2'd0;
    localparam logic [1:0] ORIENT_RIGHT = 2'd1;
    localparam logic [1:0] ORIENT_DOWN  = 2'd2;
    localparam logic [1:0] ORIENT_LEFT  = 2'd3;

    localparam logic [3:0] SPR_HEART   = 4'd0;
    localparam logic [3:0] SPR_PLAYER  = 4'd1;
    localparam logic [3:0] SPR_ENEMY_A = 4'd2;
    localparam logic [3:0] SPR_ENEMY_B = 4'd3;
    localparam logic [3:0] SPR_BULLET  = 4'd4;
    localparam logic [3:0] SPR_WALL    = 4'd5;
    localparam logic [3:0] SPR_KEY     = 4'd6;
    localparam logic [3:0] SPR_DOOR    = 4'd7;
    localparam logic [3:0] SPR_SKULL   = 4'd8;

    // Offset of a coordinate relative to a sprite origin falls inside the sprite.
    function automatic logic in_sprite(input logic [9:0] offset);
        return offset < 10'(SPRITE_SIZE);
    endfunction

endpackage

// File: rtl/sprite_pixel_select.sv
// Combinational pixel resolver: per-slot hit test against the buffered sprite
// rows and lowest-index-wins priority encoding.
module sprite_pixel_select #(
    parameter int NUM_SLOTS = 4
) (
    input  logic [9:0]             pixel_x,
    input  logic [NUM_SLOTS-1:0]   hit_buf,
    input  logic [8*NUM_SLOTS-1:0] row_buf,
    input  logic [10*NUM_SLOTS-1:0] x_buf,
    output logic                   any_lit,
    output logic [2:0]             win_slot
);
    import sprite_line_buffer_pkg::*;

    logic [NUM_SLOTS-1:0] lit;

    always_comb begin
        lit = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            logic [9:0] col;
            logic [7:0] row;
            // Modulo-1024 subtraction: columns left of the sprite wrap to large
            // values and fail the window test, so there is no horizontal wrap.
            col = pixel_x - x_buf[10*s +: 10];
            row = row_buf[8*s +: 8];
            lit[s] = hit_buf[s] && in_sprite(col) && row[col[2:0]];
        end
    end

    always_comb begin
        any_lit  = 1'b0;
        win_slot = 3'd0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (lit[s]) begin
                any_lit  = 1'b1;
                win_slot = 3'(s);
            end
        end
    end

endmodule

// File: rtl/sprite_line_buffer.sv
// Per-scanline sprite resolver: fetches one ROM row per slot during blanking,
// then lights pixels from the buffered rows during the visible line.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for line_start; pixel stage runs from the buffers
// ST_FETCH | reading ROM row for slot slot_cnt, one slot per cycle
module sprite_line_buffer #(
    parameter int NUM_SLOTS   = 4,
    parameter int SPRITE_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_start,
    input  logic [8:0]              next_line,
    input  logic                    video_active,
    input  logic [9:0]              pixel_x,
    input  logic [NUM_SLOTS-1:0]    entity_valid,
    input  logic [4*NUM_SLOTS-1:0]  entity_id,
    input  logic [2*NUM_SLOTS-1:0]  entity_orient,
    input  logic [10*NUM_SLOTS-1:0] entity_x,
    input  logic [9*NUM_SLOTS-1:0]  entity_y,
    output logic [3:0]              rom_sprite_id,
    output logic [1:0]              rom_orientation,
    output logic [2:0]              rom_line_index,
    input  logic [7:0]              rom_data,
    output logic                    pixel_on,
    output logic [2:0]              pixel_slot,
    output logic                    fetch_busy
);
    import sprite_line_buffer_pkg::*;

    localparam int CNT_W = $clog2(NUM_SLOTS) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]              state;
    logic [CNT_W-1:0]        slot_cnt;
    logic [8:0]              line_q;
    logic [NUM_SLOTS-1:0]    hit_buf;
    logic [8*NUM_SLOTS-1:0]  row_buf;
    logic [10*NUM_SLOTS-1:0] x_buf;

    logic       cur_valid;
    logic [3:0] cur_id;
    logic [1:0] cur_orient;
    logic [9:0] cur_x;
    logic [8:0] cur_y;
    logic [8:0] diff;
    logic       cur_hit;
    logic       fetching;
    logic       last_slot;

    always_comb begin
        cur_valid  = 1'b0;
        cur_id     = 4'd0;
        cur_orient = 2'd0;
        cur_x      = 10'd0;
        cur_y      = 9'd0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_cnt == CNT_W'(s)) begin
                cur_valid  = entity_valid[s];
                cur_id     = entity_id[4*s +: 4];
                cur_orient = entity_orient[2*s +: 2];
                cur_x      = entity_x[10*s +: 10];
                cur_y      = entity_y[9*s +: 9];
            end
        end
    end

    // Modulo-512 difference gives vertical wrap for sprites near line 511.
    assign diff      = line_q - cur_y;
    assign cur_hit   = cur_valid && (diff < 9'(SPRITE_SIZE));
    assign fetching  = (state == ST_FETCH);
    assign last_slot = (slot_cnt == CNT_W'(NUM_SLOTS - 1));

    assign fetch_busy      = fetching;
    assign rom_sprite_id   = fetching ? cur_id     : 4'd0;
    assign rom_orientation = fetching ? cur_orient : 2'd0;
    assign rom_line_index  = fetching ? diff[2:0]  : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            slot_cnt <= '0;
            line_q   <= 9'd0;
            hit_buf  <= '0;
        end else if (state == ST_IDLE) begin
            if (line_start) begin
                state    <= ST_FETCH;
                slot_cnt <= '0;
                line_q   <= next_line;
            end
        end else begin
            // A restart abandons the slot in flight; earlier slots keep their
            // contents until the new pass overwrites them.
            if (line_start) begin
                slot_cnt <= '0;
                line_q   <= next_line;
            end else begin
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (slot_cnt == CNT_W'(s)) begin
                        hit_buf[s] <= cur_hit;
                        if (cur_hit) begin
                            row_buf[8*s +: 8]  <= ~rom_data;
                            x_buf[10*s +: 10] <= cur_x;
                        end
                    end
                end
                if (last_slot) begin
                    state    <= ST_IDLE;
                    slot_cnt <= '0;
                end else begin
                    slot_cnt <= slot_cnt + CNT_W'(1);
                end
            end
        end
    end

    logic       sel_lit;
    logic [2:0] sel_slot;

    sprite_pixel_select #(
        .NUM_SLOTS(NUM_SLOTS)
    ) u_pixel_select (
        .pixel_x (pixel_x),
        .hit_buf (hit_buf),
        .row_buf (row_buf),
        .x_buf   (x_buf),
        .any_lit (sel_lit),
        .win_slot(sel_slot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on   <= 1'b0;
            pixel_slot <= 3'd0;
        end else begin
            pixel_on   <= video_active && sel_lit;
            pixel_slot <= (video_active && sel_lit) ? sel_slot : 3'd0;
        end
    end

endmodule

// File: tb/tb_sprite_line_buffer.sv
// Self-checking bench for sprite_line_buffer: directed scenarios plus random
// scanlines, with a queue-based scoreboard on the pixel outputs.
module tb_sprite_line_buffer;
    import sprite_line_buffer_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            line_start;
    logic [8:0]      next_line;
    logic            video_active;
    logic [9:0]      pixel_x;
    logic [N-1:0]    entity_valid;
    logic [4*N-1:0]  entity_id;
    logic [2*N-1:0]  entity_orient;
    logic [10*N-1:0] entity_x;
    logic [9*N-1:0]  entity_y;
    logic [3:0]      rom_sprite_id;
    logic [1:0]      rom_orientation;
    logic [2:0]      rom_line_index;
    logic [7:0]      rom_data;
    logic            pixel_on;
    logic [2:0]      pixel_slot;
    logic            fetch_busy;

    sprite_line_buffer #(.NUM_SLOTS(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .next_line      (next_line),
        .video_active   (video_active),
        .pixel_x        (pixel_x),
        .entity_valid   (entity_valid),
        .entity_id      (entity_id),
        .entity_orient  (entity_orient),
        .entity_x       (entity_x),
        .entity_y       (entity_y),
        .rom_sprite_id  (rom_sprite_id),
        .rom_orientation(rom_orientation),
        .rom_line_index (rom_line_index),
        .rom_data       (rom_data),
        .pixel_on       (pixel_on),
        .pixel_slot     (pixel_slot),
        .fetch_busy     (fetch_busy)
    );

    always #5 clk = ~clk;

    // Sprite ROM model (active-low rows); heart/UP row 2 is fully lit.
    function automatic logic [7:0] rom_fn(input logic [3:0] id, input logic [1:0] o,
                                          input logic [2:0] l);
        logic [15:0] h;
        if (id == SPR_HEART && o == ORIENT_UP) begin
            case (l)
                3'd0: return 8'h99;
                3'd1: return 8'h00;
                3'd2: return 8'h00;
                3'd3: return 8'h00;
                3'd4: return 8'h81;
                3'd5: return 8'hC3;
                3'd6: return 8'hE7;
                default: return 8'hFF;
            endcase
        end
        h = {7'd0, id, o, l} * 16'd40503;
        return h[11:4];
    endfunction

    assign rom_data = rom_fn(rom_sprite_id, rom_orientation, rom_line_index);

    typedef struct packed {
        logic       on;
        logic [2:0] slot;
        logic [9:0] px;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic px_req = 1'b0;

    int         e_valid[N];
    int         e_id[N];
    int         e_or[N];
    int         e_x[N];
    int         e_y[N];
    bit         m_hit[N];
    logic [7:0] m_row[N];
    int         m_x[N];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_entities();
        for (int s = 0; s < N; s++) begin
            entity_valid[s]        = (e_valid[s] != 0);
            entity_id[4*s +: 4]    = 4'(e_id[s]);
            entity_orient[2*s +: 2] = 2'(e_or[s]);
            entity_x[10*s +: 10]   = 10'(e_x[s]);
            entity_y[9*s +: 9]     = 9'(e_y[s]);
        end
    endtask

    function automatic int wrap_diff(input int line, input int y);
        return (line - y + 512) % 512;
    endfunction

    // Reference: what the buffers should hold after a completed fetch of the given line.
    task automatic model_fetch(input int line);
        for (int s = 0; s < N; s++) begin
            int d;
            d = wrap_diff(line, e_y[s]);
            m_hit[s] = (e_valid[s] != 0) && (d < SPRITE_SIZE);
            m_row[s] = ~rom_fn(4'(e_id[s]), 2'(e_or[s]), 3'(d));
            m_x[s]   = e_x[s];
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < N; s++) m_hit[s] = 0;
    endtask

    function automatic exp_t expect_px(input int px, input bit va);
        exp_t e;
        e.on   = 1'b0;
        e.slot = 3'd0;
        e.px   = 10'(px);
        if (va) begin
            for (int s = 0; s < N; s++) begin
                if (!e.on && m_hit[s] && px >= m_x[s] && px < m_x[s] + SPRITE_SIZE
                    && m_row[s][px - m_x[s]]) begin
                    e.on   = 1'b1;
                    e.slot = 3'(s);
                end
            end
        end
        return e;
    endfunction

    task automatic fetch(input int line);
        @(negedge clk);
        line_start = 1'b1;
        next_line  = 9'(line);
        @(negedge clk);
        line_start = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("fetch_busy slot%0d", k), int'(fetch_busy), 1);
            check($sformatf("rom_sprite_id slot%0d", k), int'(rom_sprite_id), e_id[k]);
            check($sformatf("rom_orientation slot%0d", k), int'(rom_orientation), e_or[k]);
            check($sformatf("rom_line_index slot%0d", k), int'(rom_line_index),
                  wrap_diff(line, e_y[k]) % 8);
        end
        @(negedge clk);
        check("fetch_busy after fetch", int'(fetch_busy), 0);
        model_fetch(line);
    endtask

    task automatic sweep(input int lo, input int hi, input bit rnd_va);
        for (int px = lo; px <= hi; px++) begin
            bit va;
            @(negedge clk);
            va = rnd_va ? ($urandom_range(0, 9) != 0) : 1'b1;
            pixel_x      = 10'(px);
            video_active = va;
            px_req       = 1'b1;
            q.push_back(expect_px(px, va));
        end
        @(negedge clk);
        px_req       = 1'b0;
        video_active = 1'b0;
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    endtask

    // Monitor: output registered at this edge belongs to the pixel driven before it.
    initial begin
        bit   pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = px_req;
            #1;
            if (pend) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL scoreboard: output present, got nothing expected");
                end else begin
                    e = q.pop_front();
                    check($sformatf("pixel_on x=%0d", e.px), int'(pixel_on), int'(e.on));
                    check($sformatf("pixel_slot x=%0d", e.px), int'(pixel_slot), int'(e.slot));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int guard;

        reset = 1'b1;
        line_start = 1'b0;
        next_line = 9'd0;
        video_active = 1'b0;
        pixel_x = 10'd0;
        for (int s = 0; s < N; s++) begin
            e_valid[s] = 0; e_id[s] = 0; e_or[s] = 0; e_x[s] = 0; e_y[s] = 0;
        end
        drive_entities();
        model_clear();
        repeat (3) @(negedge clk);
        check("reset pixel_on", int'(pixel_on), 0);
        check("reset pixel_slot", int'(pixel_slot), 0);
        check("reset fetch_busy", int'(fetch_busy), 0);
        check("reset rom_sprite_id", int'(rom_sprite_id), 0);
        check("reset rom_line_index", int'(rom_line_index), 0);
        reset = 1'b0;

        // Reset wins over a simultaneous line_start.
        @(negedge clk);
        reset = 1'b1;
        line_start = 1'b1;
        @(negedge clk);
        check("reset over line_start busy", int'(fetch_busy), 0);
        check("reset over line_start rom_orientation", int'(rom_orientation), 0);
        reset = 1'b0;
        line_start = 1'b0;

        // Heart at (100,50), line 52: row 2 fully lit.
        e_valid[0] = 1; e_id[0] = SPR_HEART; e_or[0] = ORIENT_UP; e_x[0] = 100; e_y[0] = 50;
        for (int s = 1; s < N; s++) begin
            e_valid[s] = 0; e_id[s] = s; e_or[s] = s % 4; e_x[s] = 300; e_y[s] = 300;
        end
        drive_entities();
        fetch(52);
        sweep(98, 109, 1'b0);

        // Overlapping slots 0 and 1: lower index wins; then slot 0 disabled.
        e_valid[1] = 1; e_id[1] = SPR_HEART; e_or[1] = ORIENT_UP; e_x[1] = 200; e_y[1] = 10;
        e_x[0] = 200; e_y[0] = 10;
        drive_entities();
        fetch(10);
        sweep(196, 210, 1'b0);
        e_valid[0] = 0;
        drive_entities();
        fetch(10);
        sweep(196, 210, 1'b0);

        // Vertical wrap: y=510 shows rows 2/3 on lines 0/1; line 6 is past it.
        e_valid[0] = 1; e_id[0] = SPR_ENEMY_A; e_or[0] = ORIENT_RIGHT; e_x[0] = 40; e_y[0] = 510;
        e_valid[1] = 0;
        drive_entities();
        fetch(1);
        sweep(36, 50, 1'b0);
        fetch(6);
        sweep(36, 50, 1'b0);

        // Restart two cycles into a fetch.
        for (int s = 0; s < N; s++) begin
            e_valid[s] = 1; e_id[s] = s + 1; e_or[s] = (s + 2) % 4;
            e_x[s] = 320 + 4 * s; e_y[s] = 100;
        end
        drive_entities();
        @(negedge clk);
        line_start = 1'b1;
        next_line  = 9'd200;
        @(negedge clk);
        line_start = 1'b0;
        busy_cnt = fetch_busy ? 1 : 0;
        @(negedge clk);
        if (fetch_busy) busy_cnt++;
        line_start = 1'b1;
        next_line  = 9'd103;
        @(negedge clk);
        line_start = 1'b0;
        check("restart rom_sprite_id", int'(rom_sprite_id), e_id[0]);
        check("restart rom_line_index", int'(rom_line_index), 3);
        if (fetch_busy) busy_cnt++;
        guard = 0;
        while (fetch_busy && guard < 20) begin
            @(negedge clk);
            guard++;
            if (fetch_busy) busy_cnt++;
        end
        check("restart busy cycles", busy_cnt, N + 2);
        model_fetch(103);
        sweep(316, 340, 1'b0);

        // Reset during the second FETCH cycle aborts the fetch and clears hits.
        @(negedge clk);
        line_start = 1'b1;
        next_line  = 9'd104;
        @(negedge clk);
        line_start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid-fetch busy", int'(fetch_busy), 0);
        check("reset mid-fetch pixel_on", int'(pixel_on), 0);
        reset = 1'b0;
        model_clear();
        sweep(0, H_ACTIVE - 1, 1'b0);

        // Right-edge clipping, no wrap into column 0.
        for (int s = 0; s < N; s++) e_valid[s] = 0;
        e_valid[0] = 1; e_id[0] = SPR_HEART; e_or[0] = ORIENT_DOWN; e_x[0] = 636; e_y[0] = 20;
        drive_entities();
        fetch(23);
        sweep(628, H_ACTIVE - 1, 1'b0);
        sweep(0, 7, 1'b0);

        // Random scanlines.
        for (int r = 0; r < 25; r++) begin
            int line;
            int base;
            line = $urandom_range(0, V_ACTIVE - 1);
            base = $urandom_range(0, 620);
            for (int s = 0; s < N; s++) begin
                e_valid[s] = ($urandom_range(0, 3) != 0);
                e_id[s]    = $urandom_range(0, 8);
                e_or[s]    = $urandom_range(0, 3);
                e_x[s]     = base + $urandom_range(0, 12);
                if (e_x[s] > H_ACTIVE - 1) e_x[s] = H_ACTIVE - 1;
                if ($urandom_range(0, 1) != 0)
                    e_y[s] = (line - $urandom_range(0, 9) + 512) % 512;
                else
                    e_y[s] = $urandom_range(0, 511);
            end
            drive_entities();
            fetch(line);
            sweep(0, H_ACTIVE - 1, 1'b1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_line_buffer.md
SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 Parameter: NUM_SLOTS, default 4, number of sprite entities resolved per scanline (1..8).
REQ-002 Parameter: SPRITE_SIZE, default 8, sprite edge in pixels; fixed by the sprite ROM and not overridden.
REQ-003 Clocking: one clock; reset is synchronous and active-high; ports named clk and reset.
REQ-004 clk  in  1  system/pixel clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 line_start  in  1  single-cycle pulse at the start of horizontal blanking.
REQ-007 next_line  in  9  scanline (0..479) to be displayed after this blanking interval.
REQ-008 video_active  in  1  high during visible pixels.
REQ-009 pixel_x  in  10  current visible column (0..639).
REQ-010 entity_valid  in  NUM_SLOTS  per-slot enable.
REQ-011 entity_id  in  4*NUM_SLOTS  sprite ID per slot; slot s occupies bits [4s+3:4s].
REQ-012 entity_orient  in  2*NUM_SLOTS  orientation per slot (UP=0, RIGHT=1, DOWN=2, LEFT=3).
REQ-013 entity_x  in  10*NUM_SLOTS  left pixel column per slot.
REQ-014 entity_y  in  9*NUM_SLOTS  top scanline per slot.
REQ-015 rom_sprite_id  out  4  ROM address: sprite ID.
REQ-016 rom_orientation  out  2  ROM address: orientation.
REQ-017 rom_line_index  out  3  ROM address: line within sprite.
REQ-018 rom_data  in  8  combinational ROM row; bit i = column i; 0 = pixel on (active-low).
REQ-019 pixel_on  out  1  registered: an entity pixel is lit at the previous cycle's pixel_x.
REQ-020 pixel_slot  out  3  registered: index of the winning slot; 0 when pixel_on=0.
REQ-021 fetch_busy  out  1  high while the FSM is in FETCH.

Function
REQ-022 The FSM SHALL have states IDLE and FETCH, with a slot counter of width clog2(NUM_SLOTS)+1.
REQ-023 IDLE + line_start: go to FETCH, counter = 0, latch next_line into line_q.
REQ-024 FETCH: one slot per cycle; after slot NUM_SLOTS-1 is processed, go to IDLE; fetch takes exactly NUM_SLOTS cycles.
REQ-025 Slot s hits when entity_valid[s] is set and diff = (line_q - entity_y[s]) mod 512 < 8.
REQ-026 During FETCH of slot s, the ROM outputs SHALL carry entity_id[s], entity_orient[s] and diff[2:0]; in IDLE they are 0.
REQ-027 On a hit, the same cycle SHALL capture row_buf[s] = ~rom_data, x_buf[s] = entity_x[s] and hit_buf[s] = 1.
REQ-028 On a miss, hit_buf[s] SHALL be cleared; row_buf[s] and x_buf[s] are don't-care.
REQ-029 line_start during FETCH: restart at slot 0 with the new next_line; slots already written stay until overwritten.
REQ-030 Pixel stage: col_s = (pixel_x - x_buf[s]) mod 1024; slot s is lit when hit_buf[s] is set, col_s < 8 and row_buf[s][col_s[2:0]] is 1.
REQ-031 Priority: the lowest lit slot index wins.
REQ-032 pixel_on and pixel_slot SHALL be registered, with a latency of 1 cycle from pixel_x/video_active.
REQ-033 video_active=0 SHALL force pixel_on=0 and pixel_slot=0 on the next cycle.
REQ-034 Sprites with x > 632 are clipped at the right edge; there is no horizontal wrap.
REQ-035 Vertical wrap is intended: entity_y=510 is visible on lines 0 and 1 (rows 2, 3).

Reset
REQ-036 reset SHALL force: state IDLE, counter 0, line_q 0, all hit_buf 0, pixel_on 0, pixel_slot 0, fetch_busy 0, ROM outputs 0.
REQ-037 reset SHALL override line_start in the same cycle, and reset mid-FETCH aborts the fetch with no buffer write.

Structure
REQ-038 A shared package SHALL hold the orientation constants (UP/RIGHT/DOWN/LEFT), SPRITE_SIZE, H_ACTIVE=640, V_ACTIVE=480, and the sprite ID constants 0..8.
REQ-039 The design SHALL have one sub-module, sprite_pixel_select: a combinational per-slot hit test and priority encoder instantiated by the pixel stage.

Verification
REQ-040 Scenario: slot0 = {id 0 heart, UP, x=100, y=50}, line_start with next_line=52, then sweep pixel_x 98..109 -> pixel_on = 1 exactly at columns 100..107 where heart row 2 is lit (all 8), reported one cycle later.
REQ-041 Scenario: slot0 and slot1 both at x=200, y=10, line 10 -> pixel_slot=0 wherever both are lit; with slot0 invalid -> pixel_slot=1.
REQ-042 Scenario: entity_y=510, next_line=1 -> rom_line_index=3 during FETCH; next_line=6 -> no hit.
REQ-043 Scenario: line_start, then a second line_start 2 cycles later -> fetch_busy stays high for 2+NUM_SLOTS cycles and ROM addresses restart at slot 0.
REQ-044 Scenario: reset asserted during cycle 2 of FETCH -> next cycle fetch_busy=0, pixel_on=0 for every pixel_x on the subsequent line.
REQ-045 Scenario: entity_x=636, DOWN orientation -> only columns 636..639 can light, and no pixel appears at pixel_x 0..3.
